// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared widths and write-port record for the register-file write scheduler
package rf_sched_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int STARVE_CNT_W = 4;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_sched_fifo.sv
// rf_sched_fifo: small result buffer holding completed long-latency writes in arrival order
module rf_sched_fifo
  import rf_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  rf_wr_t din,
  output rf_wr_t head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  rf_wr_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  assign full = count == DEPTH_C;
  assign empty = count == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: shares the RF write port between WB and an out-of-order long-latency unit
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic lu_ready,
  input  logic issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  output logic issue_ready,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  output logic hazard_stall,
  output logic wb_hold,
  output logic rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NUM_REGS-1:0] pending_mask
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  rf_wr_t head;
  logic [CW-1:0] count;
  logic full, empty, push, wb_req, fifo_win, wb_win, fifo_commit, issue_fire;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  logic [STARVE_CNT_W-1:0] starve_cnt, starve_nxt;
  rf_sched_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(fifo_win),
    .din({lu_addr, lu_data}),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    lu_ready = count < DEPTH_C;
    push = lu_valid && !full;
    wb_req = wb_reg_write && wb_addr != '0 && !reset;
    fifo_win = !empty && (wb_hold || !wb_req);
    wb_win = wb_req && !fifo_win;
    fifo_commit = fifo_win && head.addr != '0;
    rf_we = wb_win || fifo_commit;
    rf_waddr = wb_win ? wb_addr : fifo_commit ? head.addr : '0;
    rf_wdata = wb_win ? wb_data : fifo_commit ? head.data : '0;
    issue_ready = !pending_mask[issue_addr];
    issue_fire = issue_valid && issue_ready && issue_addr != '0;
    set_mask = issue_fire ? NUM_REGS'(1) << issue_addr : '0;
    clr_mask = fifo_commit ? NUM_REGS'(1) << head.addr : '0;
    hazard_stall = pending_mask[id_rs_addr] || pending_mask[id_rt_addr] || pending_mask[id_rd_addr];
    starve_nxt = (fifo_win || empty) ? '0 : wb_win ? starve_cnt + 1'b1 : starve_cnt;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending_mask <= '0;
      starve_cnt <= '0;
      wb_hold <= 1'b0;
    end else begin
      pending_mask <= (pending_mask & ~clr_mask) | set_mask;
      starve_cnt <= starve_nxt;
      wb_hold <= starve_nxt >= LIMIT;
    end
endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb_rf_write_scheduler: directed scoreboard bench for the RF write scheduler
module tb_rf_write_scheduler;
  import rf_sched_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wb_reg_write = 1'b0, lu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0] wb_addr = '0, lu_addr = '0, issue_addr = '0;
  logic [4:0] id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0;
  logic [31:0] wb_data = '0, lu_data = '0;
  logic lu_ready, issue_ready, hazard_stall, wb_hold, rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, pending_mask;
  int checks = 0;
  int errors = 0;
  rf_wr_t exp_q[$];
  rf_wr_t mon_e;
  always #5 clk = ~clk;
  rf_write_scheduler #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .wb_reg_write(wb_reg_write),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .lu_valid(lu_valid),
    .lu_addr(lu_addr),
    .lu_data(lu_data),
    .lu_ready(lu_ready),
    .issue_valid(issue_valid),
    .issue_addr(issue_addr),
    .issue_ready(issue_ready),
    .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr),
    .hazard_stall(hazard_stall),
    .wb_hold(wb_hold),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .pending_mask(pending_mask)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_lu_ready"}, lu_ready, 1);
    chk({p, "_issue_ready"}, issue_ready, 1);
    chk({p, "_hazard_stall"}, hazard_stall, 0);
    chk({p, "_wb_hold"}, wb_hold, 0);
    chk({p, "_rf_we"}, rf_we, 0);
    chk({p, "_rf_waddr"}, rf_waddr, 0);
    chk({p, "_rf_wdata"}, rf_wdata, 0);
    chk({p, "_pending_mask"}, pending_mask, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask
  always @(negedge clk)
    if (rf_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", rf_we, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", rf_waddr, mon_e.addr);
        chk("wr_data", rf_wdata, mon_e.data);
      end
    end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    reset = 1'b0;
    tick();
    issue_valid = 1; issue_addr = 5;
    #1 chk("issue_ready_free", issue_ready, 1);
    tick();
    issue_valid = 0; id_rs_addr = 5;
    #1 chk("stall_rs5", hazard_stall, 1);
    chk("pending5", pending_mask, 32'h20);
    chk("lu_ready_idle", lu_ready, 1);
    lu_valid = 1; lu_addr = 5; lu_data = 32'h1234;
    expect_wr(5, 32'h1234);
    tick();
    lu_valid = 0;
    #1 chk("lu_write_en", rf_we, 1);
    chk("stall_before_commit", hazard_stall, 1);
    tick();
    #1 chk("stall_drop", hazard_stall, 0);
    chk("pending5_clear", pending_mask, 0);
    id_rs_addr = 0;
    wb_reg_write = 1; wb_addr = 8; wb_data = 100;
    expect_wr(8, 100);
    lu_valid = 1; lu_addr = 9; lu_data = 32'hAA; issue_valid = 1; issue_addr = 9;
    tick();
    lu_valid = 0; issue_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      wb_data = 32'(100 + i);
      expect_wr(8, 32'(100 + i));
      #1 chk("no_hold_yet", wb_hold, 0);
      tick();
    end
    wb_data = 105;
    expect_wr(9, 32'hAA);
    #1 chk("hold_set", wb_hold, 1);
    chk("hold_waddr", rf_waddr, 9);
    chk("pending9", pending_mask, 32'h200);
    tick();
    wb_data = 106;
    expect_wr(8, 106);
    #1 chk("hold_clear", wb_hold, 0);
    chk("pending9_clear", pending_mask, 0);
    tick();
    wb_data = 200; expect_wr(8, 200);
    lu_valid = 1; lu_addr = 10; lu_data = 32'hB1;
    #1 chk("lu_ready_empty", lu_ready, 1);
    tick();
    wb_data = 201; expect_wr(8, 201);
    lu_addr = 11; lu_data = 32'hB2;
    #1 chk("lu_ready_one", lu_ready, 1);
    tick();
    lu_addr = 12; lu_data = 32'hB3;
    for (int i = 2; i <= 4; i++) begin
      wb_data = 32'(200 + i);
      expect_wr(8, 32'(200 + i));
      #1 chk("lu_ready_full", lu_ready, 0);
      tick();
    end
    wb_data = 205;
    expect_wr(10, 32'hB1);
    #1 chk("full_pop_no_push", lu_ready, 0);
    chk("hold_fill", wb_hold, 1);
    tick();
    wb_reg_write = 0;
    expect_wr(11, 32'hB2);
    #1 chk("lu_ready_after_pop", lu_ready, 1);
    chk("hold_fill_clear", wb_hold, 0);
    tick();
    lu_valid = 0;
    expect_wr(12, 32'hB3);
    #1 chk("third_result_addr", rf_waddr, 12);
    tick();
    #1 chk("drained", rf_we, 0);
    issue_valid = 1; issue_addr = 0;
    #1 chk("issue_x0_ready", issue_ready, 1);
    tick();
    issue_valid = 0;
    #1 chk("x0_no_pending", pending_mask, 0);
    lu_valid = 1; lu_addr = 0; lu_data = 32'hDEAD;
    tick();
    lu_addr = 3; lu_data = 32'h33;
    #1 chk("x0_no_write", rf_we, 0);
    chk("x0_waddr", rf_waddr, 0);
    tick();
    lu_valid = 0;
    expect_wr(3, 32'h33);
    #1 chk("after_x0_pop", rf_we, 1);
    tick();
    issue_valid = 1; issue_addr = 7;
    tick();
    id_rd_addr = 7;
    #1 chk("issue_busy", issue_ready, 0);
    chk("stall_rd7", hazard_stall, 1);
    chk("pending7", pending_mask, 32'h80);
    tick();
    issue_valid = 0;
    #1 chk("pending7_unchanged", pending_mask, 32'h80);
    lu_valid = 1; lu_addr = 7; lu_data = 32'h77;
    tick();
    lu_valid = 0;
    expect_wr(7, 32'h77);
    #1 chk("x7_write", rf_we, 1);
    tick();
    #1 chk("stall_rd7_drop", hazard_stall, 0);
    id_rd_addr = 0;
    wb_reg_write = 1; wb_addr = 8; wb_data = 300; expect_wr(8, 300);
    issue_valid = 1; issue_addr = 14; lu_valid = 1; lu_addr = 14; lu_data = 32'hE;
    tick();
    wb_data = 301; expect_wr(8, 301);
    issue_addr = 15; lu_addr = 15; lu_data = 32'hF;
    tick();
    wb_reg_write = 0; issue_valid = 0; lu_valid = 0;
    #1 chk("full_before_reset", lu_ready, 0);
    chk("pending_before_reset", pending_mask, 32'hC000);
    chk("draining", rf_we, 1);
    #1 reset = 1'b1;
    #1 chk_reset("reset_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    #1 chk("post_reset_no_write", rf_we, 0);
    chk("post_reset_pending", pending_mask, 0);
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Shares the single register-file write port between the pipeline WB stage and a long-latency unit (multiply/divide result path) that completes out of order. Tracks pending destinations in a 32-bit scoreboard and raises an ID-stage stall on RAW/WAW against pending registers. Buffers completed results in a small FIFO and prevents starvation with a bounded WB hold. Sits between WB, the long-latency unit, ID hazard logic and the register file write inputs.

## Interface
- FIFO_DEPTH, 2: long-latency result buffer entries (2 or 4).
- STARVE_LIMIT, 4: consecutive lost-arbitration cycles before `wb_hold` asserts (1..15).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- wb_reg_write  in  1  WB requests a write.
- wb_addr  in  5  WB destination.
- wb_data  in  32  WB data.
- lu_valid  in  1  long-latency result offered.
- lu_addr  in  5  result destination.
- lu_data  in  32  result data.
- lu_ready  out  1  result accepted when `lu_valid & lu_ready` at a rising edge.
- issue_valid  in  1  long-latency op issuing, reserving `issue_addr`.
- issue_addr  in  5  reserved destination.
- issue_ready  out  1  `!pending[issue_addr]`; issue only counts when both are high.
- id_rs_addr, id_rt_addr, id_rd_addr  in  5 each  ID-stage sources and destination.
- hazard_stall  out  1  ID must stall.
- wb_hold  out  1  pipeline must freeze MEM/WB this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- pending_mask  out  32  scoreboard, for debug.

## Operation
- WB request: `wb_reg_write & wb_addr!=0`. WB writes to x0 are ignored.
- Arbitration, combinational each cycle:
  - If `wb_hold` is high and the FIFO is non-empty, the FIFO head wins.
  - Otherwise, if there is a WB request, WB wins.
  - Otherwise, if the FIFO is non-empty, the head wins.
  - Otherwise `rf_we=0`, and `rf_waddr`/`rf_wdata` are 0.
- A head winning the port is popped at that edge. If the head address is 0, it is popped with `rf_we=0`.
- FIFO: `lu_ready = (count < FIFO_DEPTH)`, computed from registered count. Push and pop may occur in the same cycle when not full. When full, a pop in a cycle does not enable a push in that same cycle.
- Scoreboard:
  - Set: a fire with `issue_addr!=0` sets `pending[issue_addr]` at the edge.
  - Clear: the bit is cleared at the edge where the FIFO head for that address commits to the RF.
  - Set and clear of different addresses in one cycle both apply. The same address cannot occur because `issue_ready=0`.
- `hazard_stall = pending[rs]|pending[rt]|pending[rd]`. Address 0 never contributes.
- Starvation counter (4 bits):
  - Increments each cycle the FIFO is non-empty and WB wins.
  - Clears on any FIFO pop or when the FIFO is empty.
  - `wb_hold` is registered: it is 1 in the cycle after the counter reaches STARVE_LIMIT, and stays 1 until the pop.
- Reset, async: FIFO emptied, scoreboard cleared, counter 0. Results in flight are discarded.
- Reset values: `lu_ready=1`, `issue_ready=1`, `hazard_stall=0`, `wb_hold=0`, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `pending_mask=0`.

## Timing
- Result accepted at edge N: earliest RF write is driven in cycle N..N+1 and commits at edge N+1. The pending bit also clears at edge N+1.
- The RF is read on the falling edge, so ID sees the new value in the same cycle `hazard_stall` drops (cycle after commit edge).
- WB path: zero latency, combinational pass-through to `rf_*`.
- Worst-case FIFO wait with continuous WB: STARVE_LIMIT+1 cycles.
- `issue_ready` and `hazard_stall` are combinational from registered scoreboard and current addresses.

## Structure
- Shared package `rf_sched_pkg` holds:
  - REG_ADDR_W=5, DATA_W=32.
  - `rf_wr_t` struct {addr, data}.
  - STARVE_CNT_W=4.
- Sub-module `rf_sched_fifo`: parameterised depth, synchronous push/pop, async reset, outputs `head`, `count`, `full`, `empty`.
- Top holds arbitration, scoreboard and starvation counter.

## Test plan
- Issue x5, then ID reads rs=5 → `hazard_stall=1`. Result {5,0x1234} is accepted, WB idle → `rf_we=1` to x5 with 0x1234 next cycle, `pending[5]` clears, stall drops.
- Continuous WB to x8, FIFO holding {9,0xAA} → WB wins for 4 cycles, then `wb_hold=1`. The FIFO writes x9, and `wb_hold=0` the following cycle.
- Fill FIFO (2 results, WB busy) → `lu_ready=0`. A third `lu_valid` is not accepted until after a pop.
- Issue to x0 → `pending_mask` stays 0. Result with addr 0 → popped, `rf_we=0`.
- `issue_valid` to x7 while `pending[7]=1` → `issue_ready=0`, no scoreboard change.
- Assert reset mid-drain with FIFO count=2 and pending bits set → all outputs return to reset values immediately, with no RF write.
